clip_refresh_sequencer: RTL and testbench

- Parametrised refresh-timing sequencer for the clipper.
- Once per refresh period, if the scene has changed, it walks the object table and issues PTS_PER_OBJ point cycles per object.
- It drives the object-RAM address and per-point strobes to the clipping datapath, stalls on `writing`, and reports done or overrun.
- Sits between the object map register file and the clip datapath.

---
 rtl/clip_refresh_sequencer.sv | 173 +++++++++++++++++
 tb/tb_clip_refresh_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clip_refresh_sequencer.sv
// Refresh-timing sequencer: once per frame, if the scene is dirty, walks the object
// table issuing PTS_PER_OBJ point strobes per object. Optional macro: CLIP_SKIP_EMPTY_EN.
module clip_refresh_sequencer #(
  parameter int REFRESH_PERIOD = 1666667,
  parameter int REFRESH_WINDOW = 128,
  parameter int NUM_OBJ        = 32,
  parameter int PTS_PER_OBJ    = 4,
  localparam int OBJ_W         = $clog2(NUM_OBJ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_OBJ-1:0]     obj_map,
  input  logic                   changed,
  input  logic                   writing,
  output logic [OBJ_W-1:0]       addr,
  output logic [OBJ_W-1:0]       prev_addr,
  output logic                   refresh_en,
  output logic                   start_refresh,
  output logic                   end_refresh,
  output logic [PTS_PER_OBJ-1:0] cycle_onehot,
  output logic                   obj_vld,
  output logic                   prev_obj_vld,
  output logic                   clr_changed,
  output logic                   done,
  output logic                   overrun
);

  localparam int CNT_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int WIN_W = (REFRESH_WINDOW > 1) ? $clog2(REFRESH_WINDOW) : 1;
  localparam int PT_W  = $clog2(PTS_PER_OBJ);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [PT_W-1:0]    pt_cnt_q;
  logic [NUM_OBJ-1:0] map_q;
  logic [OBJ_W-1:0]   addr_q, prev_addr_q;
  logic               refresh_en_q, end_refresh_q, done_q, overrun_q;
  logic               clr_changed_q, prev_obj_vld_q;

  logic [OBJ_W-1:0]   first_idx, next_idx;
  logic               first_found, next_found;
  logic               last_pt, advance, complete;

  // Free-running frame counter; the tick is the last count of each frame.
  assign start_refresh = (cnt_q == CNT_W'(REFRESH_PERIOD - 1));
  assign cnt_d         = start_refresh ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // First object is searched in the live map (snapshot happens the same edge);
  // the next object is always searched in the frozen snapshot.
  always_comb begin
    first_idx   = '0;
    first_found = 1'b0;
    next_idx    = addr_q;
    next_found  = 1'b0;
`ifdef CLIP_SKIP_EMPTY_EN
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (obj_map[i]) begin
        first_idx   = OBJ_W'(i);
        first_found = 1'b1;
      end
      if (map_q[i] && (OBJ_W'(i) > addr_q)) begin
        next_idx   = OBJ_W'(i);
        next_found = 1'b1;
      end
    end
`else
    first_found = 1'b1;
    next_idx    = addr_q + OBJ_W'(1);
    next_found  = (addr_q != OBJ_W'(NUM_OBJ - 1));
`endif
  end

  assign last_pt  = (pt_cnt_q == PT_W'(PTS_PER_OBJ - 1));
  assign advance  = !writing && last_pt;
  assign complete = advance && !next_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      win_cnt_q      <= '0;
      pt_cnt_q       <= '0;
      map_q          <= '0;
      addr_q         <= '0;
      prev_addr_q    <= '0;
      refresh_en_q   <= 1'b0;
      end_refresh_q  <= 1'b0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
      clr_changed_q  <= 1'b0;
      prev_obj_vld_q <= 1'b0;
    end else begin
      end_refresh_q <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      clr_changed_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_refresh && changed) begin
            map_q     <= obj_map;
            pt_cnt_q  <= '0;
            win_cnt_q <= '0;
            if (first_found) begin
              addr_q       <= first_idx;
              refresh_en_q <= 1'b1;
              state_q      <= SCAN;
            end else begin
              end_refresh_q <= 1'b1;
              done_q        <= 1'b1;
              clr_changed_q <= 1'b1;
              state_q       <= FIN;
            end
          end
        end
        SCAN: begin
          win_cnt_q <= win_cnt_q + WIN_W'(1);
          if (!writing) begin
            if (last_pt) begin
              prev_addr_q    <= addr_q;
              prev_obj_vld_q <= map_q[addr_q];
              pt_cnt_q       <= '0;
              if (next_found) addr_q <= next_idx;
            end else begin
              pt_cnt_q <= pt_cnt_q + PT_W'(1);
            end
          end
          if (complete) begin
            refresh_en_q   <= 1'b0;
            prev_obj_vld_q <= 1'b0;
            end_refresh_q  <= 1'b1;
            done_q         <= 1'b1;
            clr_changed_q  <= 1'b1;
            state_q        <= FIN;
          end else if (win_cnt_q == WIN_W'(REFRESH_WINDOW - 1)) begin
            // Abort leaves changed set so the scan retries next frame.
            refresh_en_q   <= 1'b0;
            prev_obj_vld_q <= 1'b0;
            end_refresh_q  <= 1'b1;
            overrun_q      <= 1'b1;
            state_q        <= FIN;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PTS_PER_OBJ; gi++) begin : g_onehot
      assign cycle_onehot[gi] = refresh_en_q && !writing && (pt_cnt_q == PT_W'(gi));
    end
  endgenerate

  assign addr         = addr_q;
  assign prev_addr    = prev_addr_q;
  assign refresh_en   = refresh_en_q;
  assign end_refresh  = end_refresh_q;
  assign obj_vld      = refresh_en_q && map_q[addr_q];
  assign prev_obj_vld = prev_obj_vld_q;
  assign clr_changed  = clr_changed_q;
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_clip_refresh_sequencer.sv
// Directed bench for clip_refresh_sequencer (period 200, 8 objects, 4 points; a
// second instance with a 16-cycle window exercises the overrun abort).
`timescale 1ns/1ps
module tb_clip_refresh_sequencer;
`ifdef CLIP_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] obj_map = 8'h00;
  logic       changed = 1'b0;
  logic       writing = 1'b0;

  logic [2:0] addr, prev_addr;
  logic       refresh_en, start_refresh, end_refresh, obj_vld, prev_obj_vld;
  logic       clr_changed, done, overrun;
  logic [3:0] cycle_onehot;

  logic [2:0] w_addr, w_prev_addr;
  logic       w_refresh_en, w_start_refresh, w_end_refresh, w_obj_vld, w_prev_obj_vld;
  logic       w_clr_changed, w_done, w_overrun;
  logic [3:0] w_cycle_onehot;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  clip_refresh_sequencer #(.REFRESH_PERIOD(200), .REFRESH_WINDOW(64), .NUM_OBJ(8), .PTS_PER_OBJ(4)) dut (
    .clk(clk), .rst_n(rst_n), .obj_map(obj_map), .changed(changed), .writing(writing),
    .addr(addr), .prev_addr(prev_addr), .refresh_en(refresh_en), .start_refresh(start_refresh),
    .end_refresh(end_refresh), .cycle_onehot(cycle_onehot), .obj_vld(obj_vld),
    .prev_obj_vld(prev_obj_vld), .clr_changed(clr_changed), .done(done), .overrun(overrun));

  clip_refresh_sequencer #(.REFRESH_PERIOD(200), .REFRESH_WINDOW(16), .NUM_OBJ(8), .PTS_PER_OBJ(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .obj_map(obj_map), .changed(changed), .writing(writing),
    .addr(w_addr), .prev_addr(w_prev_addr), .refresh_en(w_refresh_en), .start_refresh(w_start_refresh),
    .end_refresh(w_end_refresh), .cycle_onehot(w_cycle_onehot), .obj_vld(w_obj_vld),
    .prev_obj_vld(w_prev_obj_vld), .clr_changed(w_clr_changed), .done(w_done), .overrun(w_overrun));

  // Expected object index at scan cycle k for obj_map = 8'h05.
  function automatic logic [2:0] exp_addr05(input int k);
    if (SKIP) return (k <= 4) ? 3'd0 : 3'd2;
    return 3'((k - 1) / 4);
  endfunction

  // Leaves the bench at the negedge of the start_refresh cycle (t0).
  task automatic wait_start(input int limit);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (start_refresh) begin
        seen = 1'b1;
        break;
      end
    end
    vec++;
    if (!seen) begin
      err++;
      $display("FAIL wait_start: start_refresh=0 after %0d cycles, required 1", limit);
    end
  endtask

  task automatic test_reset();
    logic [18:0] outs;
    int n;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {addr, prev_addr, refresh_en, start_refresh, end_refresh, cycle_onehot,
            obj_vld, prev_obj_vld, clr_changed, done, overrun};
    vec++;
    if (outs !== 19'd0) begin
      err++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    rst_n = 1'b1;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (start_refresh) break;
    end
    vec++;
    if (n !== 199) begin
      err++;
      $display("FAIL reset_first_tick: tick after %0d cycles, required 199", n);
    end
    $display("test_reset: first tick after %0d cycles", n);
  endtask

  task automatic test_scan_basic();
    int L;
    logic [3:0] eoh;
    L = SKIP ? 8 : 32;
    obj_map = 8'h05;
    changed = 1'b1;
    wait_start(400);
    for (int k = 1; k <= L; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      eoh = 4'(1 << ((k - 1) % 4));
      vec++;
      if (refresh_en !== 1'b1 || addr !== exp_addr05(k) || cycle_onehot !== eoh ||
          obj_vld !== (exp_addr05(k) == 3'd0 || exp_addr05(k) == 3'd2)) begin
        err++;
        $display("FAIL basic_scan k=%0d: ren=%b addr=%0d oh=%b vld=%b, required ren=1 addr=%0d oh=%b",
                 k, refresh_en, addr, cycle_onehot, obj_vld, exp_addr05(k), eoh);
      end
      if (k == 5) begin
        vec++;
        if (prev_addr !== 3'd0 || prev_obj_vld !== 1'b1) begin
          err++;
          $display("FAIL basic_prev: prev_addr=%0d prev_vld=%b, required 0/1", prev_addr, prev_obj_vld);
        end
      end
    end
    @(posedge clk); #1;
    changed = 1'b0;
    @(negedge clk);
    vec++;
    if ({refresh_en, end_refresh, done, clr_changed, overrun, obj_vld, prev_obj_vld} !== 7'b0111000 ||
        prev_addr !== (SKIP ? 3'd2 : 3'd7)) begin
      err++;
      $display("FAIL basic_fin: ren/end/done/clr/ovr/vld/pvld=%b%b%b%b%b%b%b prev=%0d, required 0111000 prev=%0d",
               refresh_en, end_refresh, done, clr_changed, overrun, obj_vld, prev_obj_vld,
               prev_addr, SKIP ? 2 : 7);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vec++;
    if ({refresh_en, end_refresh, done, clr_changed} !== 4'b0000) begin
      err++;
      $display("FAIL basic_idle: ren/end/done/clr=%b%b%b%b, required 0000",
               refresh_en, end_refresh, done, clr_changed);
    end
    $display("test_scan_basic: scan of %0d cycles finished, prev_addr=%0d", L, prev_addr);
  endtask

  task automatic test_no_change();
    int n;
    bit saw_scan;
    changed = 1'b0;
    wait_start(400);
    for (int f = 0; f < 3; f++) begin
      n = 0;
      saw_scan = 1'b0;
      while (n < 300) begin
        @(negedge clk);
        n++;
        if (refresh_en || done) saw_scan = 1'b1;
        if (start_refresh) break;
      end
      vec++;
      if (n !== 200 || saw_scan) begin
        err++;
        $display("FAIL no_change f=%0d: period=%0d scan_seen=%b, required 200/0", f, n, saw_scan);
      end
      $display("test_no_change: frame %0d period %0d", f, n);
    end
  endtask

  task automatic test_writing_stall();
    int S, FINK, kk;
    bit stalled;
    logic [3:0] eoh;
    S = SKIP ? 6 : 10;
    FINK = (SKIP ? 8 : 32) + 4;
    obj_map = 8'h05;
    changed = 1'b1;
    wait_start(400);
    for (int k = 1; k <= FINK; k++) begin
      @(posedge clk); #1;
      stalled = (k >= S && k <= S + 2);
      writing = stalled;
      @(negedge clk);
      if (k < FINK) begin
        kk = (k < S) ? k : (stalled ? S : k - 3);
        eoh = stalled ? 4'b0000 : 4'(1 << ((kk - 1) % 4));
        vec++;
        if (refresh_en !== 1'b1 || cycle_onehot !== eoh || addr !== exp_addr05(kk)) begin
          err++;
          $display("FAIL stall k=%0d: ren=%b oh=%b addr=%0d, required ren=1 oh=%b addr=%0d",
                   k, refresh_en, cycle_onehot, addr, eoh, exp_addr05(kk));
        end
      end else begin
        changed = 1'b0;
        vec++;
        if (refresh_en !== 1'b0 || end_refresh !== 1'b1 || done !== 1'b1) begin
          err++;
          $display("FAIL stall_fin k=%0d: ren=%b end=%b done=%b, required 0/1/1",
                   k, refresh_en, end_refresh, done);
        end
      end
    end
    writing = 1'b0;
    $display("test_writing_stall: FIN at t0+%0d", FINK);
  endtask

  task automatic test_window_abort();
    obj_map = 8'hFF;
    changed = 1'b1;
    wait_start(400);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k <= 16) begin
        vec++;
        if (w_refresh_en !== 1'b1 || w_addr !== 3'((k - 1) / 4) || w_overrun !== 1'b0) begin
          err++;
          $display("FAIL abort_scan k=%0d: ren=%b addr=%0d ovr=%b, required 1/%0d/0",
                   k, w_refresh_en, w_addr, w_overrun, (k - 1) / 4);
        end
      end else if (k == 17) begin
        vec++;
        if ({w_refresh_en, w_end_refresh, w_overrun, w_done, w_clr_changed} !== 5'b01100 ||
            refresh_en !== 1'b1) begin
          err++;
          $display("FAIL abort_fin: ren/end/ovr/done/clr=%b%b%b%b%b wide_ren=%b, required 01100 wide_ren=1",
                   w_refresh_en, w_end_refresh, w_overrun, w_done, w_clr_changed, refresh_en);
        end
      end else begin
        vec++;
        if (w_overrun !== 1'b0 || w_refresh_en !== 1'b0) begin
          err++;
          $display("FAIL abort_idle: ovr=%b ren=%b, required 0/0", w_overrun, w_refresh_en);
        end
      end
    end
    wait_start(400);
    @(posedge clk); #1;
    changed = 1'b0;
    @(negedge clk);
    vec++;
    if (w_refresh_en !== 1'b1 || w_addr !== 3'd0 || w_cycle_onehot !== 4'b0001) begin
      err++;
      $display("FAIL abort_retry: ren=%b addr=%0d oh=%b, required 1/0/0001",
               w_refresh_en, w_addr, w_cycle_onehot);
    end
    repeat (40) @(negedge clk);
    $display("test_window_abort: overrun at t0+17, retry restarted at addr 0");
  endtask

  task automatic test_empty_map();
    int L;
    L = SKIP ? 0 : 32;
    obj_map = 8'h00;
    changed = 1'b1;
    wait_start(400);
    for (int k = 1; k <= L + 3; k++) begin
      @(posedge clk); #1;
      changed = 1'b0;
      @(negedge clk);
      vec++;
      if (k <= L) begin
        if (refresh_en !== 1'b1 || obj_vld !== 1'b0 || done !== 1'b0) begin
          err++;
          $display("FAIL empty_scan k=%0d: ren=%b vld=%b done=%b, required 1/0/0", k, refresh_en, obj_vld, done);
        end
      end else if (k == L + 1) begin
        if ({refresh_en, end_refresh, done, clr_changed, overrun} !== 5'b01110) begin
          err++;
          $display("FAIL empty_fin k=%0d: ren/end/done/clr/ovr=%b%b%b%b%b, required 01110",
                   k, refresh_en, end_refresh, done, clr_changed, overrun);
        end
      end else begin
        if (refresh_en !== 1'b0 || done !== 1'b0) begin
          err++;
          $display("FAIL empty_idle k=%0d: ren=%b done=%b, required 0/0", k, refresh_en, done);
        end
      end
    end
    $display("test_empty_map: done at t0+%0d", L + 1);
  endtask

  task automatic test_async_reset();
    logic [18:0] outs;
    int n;
    obj_map = 8'h05;
    changed = 1'b1;
    wait_start(400);
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    vec++;
    if (refresh_en !== 1'b1) begin
      err++;
      $display("FAIL areset_pre: ren=%b, required 1", refresh_en);
    end
    rst_n = 1'b0;
    changed = 1'b0;
    #1;
    outs = {addr, prev_addr, refresh_en, start_refresh, end_refresh, cycle_onehot,
            obj_vld, prev_obj_vld, clr_changed, done, overrun};
    vec++;
    if (outs !== 19'd0) begin
      err++;
      $display("FAIL areset_immediate: got %h, required 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (start_refresh) break;
    end
    vec++;
    if (n !== 199) begin
      err++;
      $display("FAIL areset_restart: tick after %0d cycles, required 199", n);
    end
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (start_refresh) break;
    end
    vec++;
    if (n !== 200) begin
      err++;
      $display("FAIL areset_period: period %0d, required 200", n);
    end
    $display("test_async_reset: counter restarted, period %0d", n);
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_no_change();
    test_writing_stall();
    test_window_abort();
    test_empty_map();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
